// File: rtl/babel_pkg.sv
// Shared types and constants for the writeback store path.
package babel_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_REQ,
    DRAIN_WACK
  } drain_state_t;

  localparam int unsigned TAG_PAD_W = 7;
  localparam logic        TAG_WRITE  = 1'b1;
  localparam logic [1:0]  TAG_MEMORY = 2'b10;
  localparam logic [2:0]  TAG_DATA   = 3'b001;

  // Tag for every store drained to the D-cache: {WRITE, MEMORY, DATA, pad}
  localparam logic [12:0] STORE_TAG = {TAG_WRITE, TAG_MEMORY, TAG_DATA, {TAG_PAD_W{1'b0}}};

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the store buffer entries for load forwarding.
module wb_fwd_match #(
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  ADDR_W = 64,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  validMask,
  input  logic [ADDR_W-1:0] addrs [DEPTH],
  input  logic [ADDR_W-1:0] lookupAddr,
  input  logic [PTR_W-1:0]  tail,
  output logic              hit,
  output logic [PTR_W-1:0]  idx
);

  logic [PTR_W-1:0] pos;

  // Walk from oldest slot to tail-1 so the last match written is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      pos = tail - PTR_W'(k + 1);
      if (validMask[pos] && (addrs[pos] == lookupAddr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/wb_store_buffer.sv
// In-order store buffer between WriteBack and the D-cache, with load forwarding.
module wb_store_buffer
  import babel_pkg::*;
#(
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  ADDR_W = 64,
  parameter int unsigned  DATA_W = 64,
  parameter int unsigned  TAG_W  = 13,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  input  logic              fence_req,
  output logic              fence_done,
  output logic              reqcyc,
  output logic [ADDR_W-1:0] req,
  output logic [DATA_W-1:0] reqdata,
  output logic [TAG_W-1:0]  reqtag,
  input  logic              reqack,
  input  logic              writeack,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       inprogress,
  output logic              did_write
);

  logic [ADDR_W-1:0] entryAddr [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  drain_state_t      state;

  logic              enqFire;
  logic              popFire;
  logic [DEPTH-1:0]  validMask;
  logic [PTR_W-1:0]  slotAge;
  logic [PTR_W-1:0]  fwdIdx;

  assign fence_done = (count == '0) && (state == DRAIN_IDLE);
  assign enq_ready  = (count != CNT_W'(DEPTH)) && !(fence_req && !fence_done);
  assign enqFire    = enq_valid && enq_ready;
  assign popFire    = ((state == DRAIN_REQ) && reqack && writeack) ||
                      ((state == DRAIN_WACK) && writeack);
  assign inprogress = 32'(count);

  // Entry payload needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (enqFire) begin
      entryAddr[tailPtr] <= enq_addr;
      entryData[tailPtr] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (enqFire) tailPtr <= tailPtr + PTR_W'(1);
      if (popFire) headPtr <= headPtr + PTR_W'(1);
      if (enqFire && !popFire)      count <= count + CNT_W'(1);
      else if (!enqFire && popFire) count <= count - CNT_W'(1);
    end
  end

  // Drain FSM: one outstanding write, request fields held until reqack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DRAIN_IDLE;
      reqcyc    <= 1'b0;
      req       <= '0;
      reqdata   <= '0;
      reqtag    <= '0;
      did_write <= 1'b0;
    end else begin
      did_write <= 1'b0;
      unique case (state)
        DRAIN_IDLE: begin
          if (count != '0) begin
            req     <= entryAddr[headPtr];
            reqdata <= entryData[headPtr];
            reqtag  <= TAG_W'(STORE_TAG);
            reqcyc  <= 1'b1;
            state   <= DRAIN_REQ;
          end
        end
        DRAIN_REQ: begin
          if (reqack) begin
            reqcyc <= 1'b0;
            if (writeack) begin
              did_write <= 1'b1;
              state     <= DRAIN_IDLE;
            end else begin
              state <= DRAIN_WACK;
            end
          end
        end
        DRAIN_WACK: begin
          if (writeack) begin
            did_write <= 1'b1;
            state     <= DRAIN_IDLE;
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
    end
  end

  // A slot is occupied when its distance from head is below count.
  always_comb begin
    validMask = '0;
    slotAge   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slotAge      = PTR_W'(i) - headPtr;
      validMask[i] = CNT_W'(slotAge) < count;
    end
  end

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fwd_match (
    .validMask (validMask),
    .addrs     (entryAddr),
    .lookupAddr(fwd_addr),
    .tail      (tailPtr),
    .hit       (fwd_hit),
    .idx       (fwdIdx)
  );

  assign fwd_data = fwd_hit ? entryData[fwdIdx] : '0;

endmodule

// File: tb/tb_wb_store_buffer.sv
// Scoreboard bench for wb_store_buffer: stimulus queues expected requests, a monitor checks them.
module tb_wb_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 13;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              fence_req;
  logic              fence_done;
  logic              reqcyc;
  logic [ADDR_W-1:0] req;
  logic [DATA_W-1:0] reqdata;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              writeack;
  logic [CNT_W-1:0]  count;
  logic [31:0]       inprogress;
  logic              did_write;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } req_t;

  req_t expQ [$];
  int   errors = 0;
  int   checks = 0;
  logic prevReqcyc = 1'b0;

  always #5 clk = ~clk;

  wb_store_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_addr  (enq_addr),
    .enq_data  (enq_data),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fence_req (fence_req),
    .fence_done(fence_done),
    .reqcyc    (reqcyc),
    .req       (req),
    .reqdata   (reqdata),
    .reqtag    (reqtag),
    .reqack    (reqack),
    .writeack  (writeack),
    .count     (count),
    .inprogress(inprogress),
    .did_write (did_write)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [63:0] a, input logic [63:0] d);
    req_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    tick();
    enq_valid = 1'b0;
  endtask

  // Wait (bounded) for a request, then acknowledge it as one or two handshakes.
  task automatic drainOne(input bit both);
    int n = 0;
    while (!reqcyc && n < 20) begin
      tick();
      n++;
    end
    if (!reqcyc) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got reqcyc=0 expected 1 within 20 cycles");
      return;
    end
    if (both) begin
      reqack   = 1'b1;
      writeack = 1'b1;
      tick();
      reqack   = 1'b0;
      writeack = 1'b0;
    end else begin
      reqack = 1'b1;
      tick();
      reqack   = 1'b0;
      writeack = 1'b1;
      tick();
      writeack = 1'b0;
    end
    check("did_write_pulse", 64'(did_write), 64'h1);
  endtask

  // Each new request is compared against the oldest expected store.
  always @(negedge clk) begin
    req_t e;
    if (reqcyc && !prevReqcyc) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got addr 0x%0h expected no request", req);
      end else begin
        e = expQ.pop_front();
        check("req_addr", req, e.addr);
        check("req_data", reqdata, e.data);
        check("req_tag", 64'(reqtag), 64'h1880);
      end
    end
    prevReqcyc = reqcyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0;
    fwd_addr = '0; fence_req = 1'b0; reqack = 1'b0; writeack = 1'b0;
    tick();
    tick();
    check("rst_reqcyc", 64'(reqcyc), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_fence_done", 64'(fence_done), 64'h1);
    check("rst_enq_ready", 64'(enq_ready), 64'h1);
    check("rst_did_write", 64'(did_write), 64'h0);
    reset = 1'b1;
    tick();

    // Reset while a request is outstanding
    enq(64'h500, 64'h55);
    tick();
    check("t1_reqcyc_up", 64'(reqcyc), 64'h1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t1_reqcyc_async", 64'(reqcyc), 64'h0);
    tick();
    check("t1_count", 64'(count), 64'h0);
    check("t1_fence_done", 64'(fence_done), 64'h1);
    reset = 1'b1;
    tick();

    // Single store with delayed writeack
    enq(64'h1000, 64'hDEAD);
    check("t2_count1", 64'(count), 64'h1);
    check("t2_inprogress", 64'(inprogress), 64'h1);
    check("t2_reqcyc_low", 64'(reqcyc), 64'h0);
    tick();
    check("t2_reqcyc", 64'(reqcyc), 64'h1);
    check("t2_req", req, 64'h1000);
    reqack = 1'b1;
    tick();
    reqack = 1'b0;
    check("t2_reqcyc_drop", 64'(reqcyc), 64'h0);
    tick();
    tick();
    writeack = 1'b1;
    tick();
    writeack = 1'b0;
    check("t2_did_write", 64'(did_write), 64'h1);
    check("t2_count0", 64'(count), 64'h0);
    tick();
    check("t2_did_write_pulse", 64'(did_write), 64'h0);

    // Fill to DEPTH, no bypass on the pop cycle, drain across the pointer wrap
    for (int i = 0; i < 4; i++) enq(64'h3100 + 64'(i) * 64'h10, 64'hA0 + 64'(i));
    check("t3_count_full", 64'(count), 64'h4);
    check("t3_enq_ready_full", 64'(enq_ready), 64'h0);
    reqack = 1'b1;
    tick();
    reqack    = 1'b0;
    writeack  = 1'b1;
    enq_valid = 1'b1;
    enq_addr  = 64'h3200;
    enq_data  = 64'hEE;
    tick();
    writeack = 1'b0;
    check("t3_no_bypass_count", 64'(count), 64'h3);
    check("t3_enq_ready_after_pop", 64'(enq_ready), 64'h1);
    check("t3_did_write", 64'(did_write), 64'h1);
    begin
      req_t e;
      e.addr = 64'h3200;
      e.data = 64'hEE;
      expQ.push_back(e);
    end
    tick();
    enq_valid = 1'b0;
    check("t3_refill_count", 64'(count), 64'h4);
    for (int i = 0; i < 4; i++) drainOne(1'b0);
    check("t3_drained", 64'(count), 64'h0);

    // Forwarding picks the youngest match
    enq(64'h2000, 64'h1);
    enq(64'h2000, 64'h2);
    fwd_addr = 64'h2000;
    #1;
    check("t4_fwd_hit", 64'(fwd_hit), 64'h1);
    check("t4_fwd_data", fwd_data, 64'h2);
    fwd_addr = 64'h3000;
    #1;
    check("t4_fwd_miss", 64'(fwd_hit), 64'h0);
    check("t4_fwd_miss_data", fwd_data, 64'h0);

    // reqack and writeack together
    reqack   = 1'b1;
    writeack = 1'b1;
    tick();
    reqack   = 1'b0;
    writeack = 1'b0;
    check("t5_did_write", 64'(did_write), 64'h1);
    check("t5_reqcyc_idle", 64'(reqcyc), 64'h0);
    check("t5_count", 64'(count), 64'h1);
    fwd_addr = 64'h2000;
    #1;
    check("t5_fwd_remaining", fwd_data, 64'h2);
    tick();
    check("t5_reqcyc_next", 64'(reqcyc), 64'h1);
    check("t5_reqdata_next", reqdata, 64'h2);
    drainOne(1'b1);
    check("t5_count0", 64'(count), 64'h0);

    // Fence with three queued stores; in-flight entry is still forwarded
    enq(64'h6000, 64'h61);
    enq(64'h6010, 64'h62);
    enq(64'h6020, 64'h63);
    fence_req = 1'b1;
    fwd_addr  = 64'h6000;
    #1;
    check("t6_fwd_inflight", fwd_data, 64'h61);
    check("t6_enq_ready", 64'(enq_ready), 64'h0);
    check("t6_fence_busy", 64'(fence_done), 64'h0);
    check("t6_inprogress", 64'(inprogress), 64'h3);
    drainOne(1'b0);
    check("t6_fence_after1", 64'(fence_done), 64'h0);
    drainOne(1'b0);
    check("t6_fence_after2", 64'(fence_done), 64'h0);
    drainOne(1'b0);
    check("t6_fence_done", 64'(fence_done), 64'h1);
    check("t6_enq_ready_done", 64'(enq_ready), 64'h1);
    fence_req = 1'b0;
    tick();
    tick();

    check("queue_empty", 64'(expQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
